// File: rtl/polar_inverse_decoder.sv
// Sequential polar inverse transform: one butterfly stage per clock, then info-bit gather.
// Define POLAR_FROZEN_CHECK_EN to compute frozen_err_o; otherwise it is tied to 0.

`ifndef N
`define N 8
`endif
`ifndef MESSAGE_LENGTH
`define MESSAGE_LENGTH 4
`endif

module polar_inverse_decoder #(
  parameter int unsigned        N         = `N,
  parameter int unsigned        K         = `MESSAGE_LENGTH,
  parameter logic [0:N-1]       INFO_MASK = 8'b0001_0111
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:N-1] code_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:K-1] infor_o,
  output logic         frozen_err_o
);

  localparam int unsigned Stages = $clog2(N);
  localparam int unsigned StgW   = $clog2(Stages) + 1;

  typedef enum logic [1:0] {StIdle, StXform, StDone} state_e;

  state_e            state_q, state_d;
  logic [0:N-1]      v_q, v_d, v_xf;
  logic [StgW-1:0]   stg_q, stg_d;

  // Index of the k-th set bit of INFO_MASK, counting from position 0.
  function automatic int info_pos(input int k);
    int pos;
    int cnt;
    pos = 0;
    cnt = 0;
    for (int i = 0; i < int'(N); i++) begin
      if (INFO_MASK[i]) begin
        if (cnt == k) pos = i;
        cnt++;
      end
    end
    return pos;
  endfunction

  // Butterfly for the stage selected by stg_q; the partner i ^ 2^s is always in range.
  always_comb begin
    v_xf = v_q;
    for (int s = 0; s < int'(Stages); s++) begin
      if (int'(stg_q) == s) begin
        for (int i = 0; i < int'(N); i++) begin
          if (((i >> s) & 1) == 0) v_xf[i] = v_q[i] ^ v_q[i ^ (1 << s)];
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    v_d       = v_q;
    stg_d     = stg_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          v_d     = code_i;
          stg_d   = '0;
          state_d = StXform;
        end
      end
      StXform: begin
        v_d   = v_xf;
        stg_d = stg_q + StgW'(1);
        if (int'(stg_q) == int'(Stages) - 1) state_d = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      v_q     <= '0;
      stg_q   <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      stg_q   <= stg_d;
    end
  end

  for (genvar k = 0; k < int'(K); k++) begin : g_info
    localparam int Pos = info_pos(k);
    assign infor_o[k] = v_q[Pos];
  end

`ifdef POLAR_FROZEN_CHECK_EN
  assign frozen_err_o = |(v_q & ~INFO_MASK);
`else
  assign frozen_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_polar_inverse_decoder.sv
// Directed bench for polar_inverse_decoder with N=8, K=4, info positions 3, 5, 6, 7.

module tb_polar_inverse_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [0:7] code_i;
  logic       out_valid;
  logic       out_ready;
  logic [0:3] infor_o;
  logic       frozen_err_o;

  int total = 0;
  int bad   = 0;

`ifdef POLAR_FROZEN_CHECK_EN
  localparam logic FeExp = 1'b1;
`else
  localparam logic FeExp = 1'b0;
`endif

  polar_inverse_decoder #(
    .N        (8),
    .K        (4),
    .INFO_MASK(8'b0001_0111)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .code_i      (code_i),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .infor_o     (infor_o),
    .frozen_err_o(frozen_err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference encoder: x[j] = XOR of u[i] over all i whose bits cover j.
  function automatic logic [0:7] encode(input logic [0:3] m);
    logic [0:7] u;
    logic [0:7] x;
    u    = '0;
    u[3] = m[0];
    u[5] = m[1];
    u[6] = m[2];
    u[7] = m[3];
    for (int j = 0; j < 8; j++) begin
      x[j] = 1'b0;
      for (int i = 0; i < 8; i++) if ((i & j) == j) x[j] = x[j] ^ u[i];
    end
    return x;
  endfunction

  // Accept one codeword and wait (bounded) for out_valid; checks the latency.
  task automatic send_and_wait(input string tag, input logic [0:7] code);
    int cyc;
    in_valid = 1'b1;
    code_i   = code;
    tick();
    in_valid = 1'b0;
    code_i   = '0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, cyc, 3);
  endtask

  initial begin
    logic [0:3] msg;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    code_i    = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_infor", infor_o, 4'b0000);
    check("rst_frozen", frozen_err_o, 0);

    // Single info bit, out_ready held high
    out_ready = 1'b1;
    send_and_wait("single", 8'b1111_0000);
    check("single_valid", out_valid, 1);
    check("single_infor", infor_o, 4'b1000);
    check("single_frozen", frozen_err_o, 0);
    check("single_in_ready", in_ready, 0);
    tick();
    check("single_done_1cyc", out_valid, 0);
    check("single_idle", in_ready, 1);

    send_and_wait("ones", 8'b1111_1111);
    check("ones_infor", infor_o, 4'b0001);
    check("ones_frozen", frozen_err_o, 0);
    tick();

    send_and_wait("frz", 8'b1000_0000);
    check("frz_infor", infor_o, 4'b0000);
    check("frz_frozen", frozen_err_o, FeExp);
    tick();

    // Backpressure: 5 stalled cycles in DONE with a stray in_valid
    out_ready = 1'b0;
    send_and_wait("bp", 8'b1111_0000);
    in_valid = 1'b1;
    code_i   = 8'b1111_1111;
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", out_valid, 1);
      check("bp_infor", infor_o, 4'b1000);
      check("bp_in_ready", in_ready, 0);
      tick();
    end
    in_valid  = 1'b0;
    code_i    = '0;
    out_ready = 1'b1;
    check("bp_last_valid", out_valid, 1);
    tick();
    check("bp_released", out_valid, 0);
    check("bp_idle", in_ready, 1);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("bp_no_extra", out_valid, 0);
    end

    // Reset during the second transform stage
    in_valid = 1'b1;
    code_i   = 8'b1111_1111;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_infor", infor_o, 4'b0000);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("midrst_quiet", out_valid, 0);
    end
    send_and_wait("after_rst", 8'b1111_0000);
    check("after_rst_infor", infor_o, 4'b1000);
    tick();

    // Reset wins over a simultaneous in_valid
    rst      = 1'b1;
    in_valid = 1'b1;
    code_i   = 8'b1111_1111;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst_vs_valid_ready", in_ready, 1);
    tick();
    check("rst_vs_valid_nocap", in_ready, 1);
    check("rst_vs_valid_out", out_valid, 0);

    // Round trip through the reference encoder
    for (int t = 0; t < 200; t++) begin
      msg = 4'($urandom_range(0, 15));
      send_and_wait("rt", encode(msg));
      check("rt_infor", infor_o, msg);
      check("rt_frozen", frozen_err_o, 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
